// File: rtl/kyber_arith_pkg.sv
// Shared Kyber arithmetic constants, default divider widths and divider FSM states.
package kyber_arith_pkg;

   localparam int unsigned KYBER_Q            = 3329;
   localparam int unsigned KYBER_COEFF_W      = 12;
   localparam int unsigned DEFAULT_DIVIDEND_W = 24;
   localparam int unsigned DEFAULT_DIVISOR_W  = KYBER_COEFF_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

endpackage : kyber_arith_pkg

// File: rtl/div_restoring_step.sv
// One radix-2 restoring step: shift in a dividend bit, compare and subtract.
module div_restoring_step #(
   parameter int unsigned DIVISOR_W = 12
) (
   input  logic [DIVISOR_W:0]   i_r,
   input  logic                 i_bit,
   input  logic [DIVISOR_W-1:0] i_d,
   output logic [DIVISOR_W:0]   o_r,
   output logic                 o_q
);

   localparam int unsigned RW = DIVISOR_W + 1;
   localparam int unsigned SW = DIVISOR_W + 2;

   logic [RW-1:0] w_t;
   logic [SW-1:0] w_sub;

   // Trial value drops the partial remainder's top bit, which is zero while R < D.
   assign w_t   = RW'({i_r, i_bit});
   // One extra bit so the borrow out doubles as the T >= D decision.
   assign w_sub = SW'(w_t) - SW'(i_d);
   assign o_q   = ~w_sub[SW-1];
   assign o_r   = o_q ? w_sub[RW-1:0] : w_t;

endmodule : div_restoring_step

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
module seq_restoring_divider
   import kyber_arith_pkg::*;
#(
   parameter int unsigned DIVIDEND_W = DEFAULT_DIVIDEND_W,
   parameter int unsigned DIVISOR_W  = DEFAULT_DIVISOR_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_by_zero
);

   localparam int unsigned CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

   div_state_e            r_state;
   logic [DIVIDEND_W-1:0] r_q;
   logic [DIVISOR_W-1:0]  r_d;
   logic [DIVISOR_W:0]    r_r;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_in_ready;
   logic                  r_out_valid;
   logic [DIVIDEND_W-1:0] r_quotient;
   logic [DIVISOR_W-1:0]  r_remainder;
   logic                  r_dbz;

   logic [DIVISOR_W:0]    w_r_next;
   logic                  w_q_bit;
   logic [DIVIDEND_W-1:0] w_q_next;

   div_restoring_step #(
      .DIVISOR_W (DIVISOR_W)
   ) u_step (
      .i_r   (r_r),
      .i_bit (r_q[DIVIDEND_W-1]),
      .i_d   (r_d),
      .o_r   (w_r_next),
      .o_q   (w_q_bit)
   );

   // Dividend bits leave at the MSB while quotient bits enter at the LSB.
   assign w_q_next = {r_q[DIVIDEND_W-2:0], w_q_bit};

   // Control FSM and datapath registers; reset discards any in-flight division.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_q         <= '0;
         r_d         <= '0;
         r_r         <= '0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dbz       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_q        <= dividend;
                  r_d        <= divisor;
                  r_r        <= '0;
                  r_cnt      <= CNT_W'(DIVIDEND_W - 1);
                  r_in_ready <= 1'b0;
                  if (divisor == '0) begin
                     r_state     <= ST_DONE;
                     r_out_valid <= 1'b1;
                     r_quotient  <= '1;
                     r_remainder <= '0;
                     r_dbz       <= 1'b1;
                  end else begin
                     r_state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               r_r <= w_r_next;
               r_q <= w_q_next;
               if (r_cnt == '0) begin
                  r_state     <= ST_DONE;
                  r_out_valid <= 1'b1;
                  r_quotient  <= w_q_next;
                  r_remainder <= DIVISOR_W'(w_r_next);
                  r_dbz       <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_state     <= ST_IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready    = r_in_ready;
   assign out_valid   = r_out_valid;
   assign quotient    = r_quotient;
   assign remainder   = r_remainder;
   assign div_by_zero = r_dbz;

endmodule : seq_restoring_divider
